// File: rtl/fpuv_wb_buffer_if.sv
// Bundle between the FPU result port, the writeback buffer and the writeback consumer.
// The FPU/consumer side uses the master modport; the buffer uses the slave modport.
interface fpuv_wb_buffer_if #(
  parameter int ELEN    = 64,
  parameter int FLAGS_W = 5,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               res_valid_i;
  logic [ELEN-1:0]    res_data_i;
  logic [FLAGS_W-1:0] res_flags_i;
  logic               stall_o;
  logic               wb_valid_o;
  logic               wb_ready_i;
  logic [ELEN-1:0]    wb_data_o;
  logic [FLAGS_W-1:0] wb_flags_o;
  logic [FLAGS_W-1:0] fflags_acc_o;
  logic               clr_fflags_i;
  logic               flush_i;
  logic [CW-1:0]      count_o;
  logic               ovf_o;

  modport master (
    output res_valid_i, res_data_i, res_flags_i, wb_ready_i, clr_fflags_i, flush_i,
    input  stall_o, wb_valid_o, wb_data_o, wb_flags_o, fflags_acc_o, count_o, ovf_o
  );

  modport slave (
    input  res_valid_i, res_data_i, res_flags_i, wb_ready_i, clr_fflags_i, flush_i,
    output stall_o, wb_valid_o, wb_data_o, wb_flags_o, fflags_acc_o, count_o, ovf_o
  );
endinterface

// File: rtl/fpuv_wb_buffer.sv
// Circular FIFO decoupling FPU results from writeback, with one-slot skid, sticky
// fflags accumulation and sticky overflow detection. DEPTH must be a power of two >= 2.
module fpuv_wb_buffer #(
  parameter int ELEN    = 64,
  parameter int DEPTH   = 4,
  parameter int FLAGS_W = 5
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  fpuv_wb_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ELEN-1:0]    data_mem  [DEPTH];
  logic [FLAGS_W-1:0] flags_mem [DEPTH];

  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, next_count;
  logic               stall_q, ovf_q;
  logic [FLAGS_W-1:0] acc_q;
  logic               not_empty, push, pop, drop;

  assign not_empty = (count != '0);
  assign pop  = not_empty && bus.wb_ready_i && !bus.flush_i;
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign push = bus.res_valid_i && !bus.flush_i && ((count < CW'(DEPTH)) || pop);
  assign drop = bus.res_valid_i && !bus.flush_i && !push;

  always_comb begin
    next_count = count;
    if (bus.flush_i) begin
      next_count = '0;
    end else if (push && !pop) begin
      next_count = count + CW'(1);
    end else if (pop && !push) begin
      next_count = count - CW'(1);
    end
  end

  // NOTE: storage has no reset; entries are only observable once count covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr]  <= bus.res_data_i;
      flags_mem[wr_ptr] <= bus.res_flags_i;
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      count   <= next_count;
      // Stall one entry early so a result already in flight still finds a slot.
      stall_q <= (next_count >= CW'(DEPTH - 1));
      if (bus.flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop) ovf_q <= 1'b1;
      if (pop) begin
        acc_q <= (bus.clr_fflags_i ? '0 : acc_q) | flags_mem[rd_ptr];
      end else if (bus.clr_fflags_i) begin
        acc_q <= '0;
      end
    end
  end

  assign bus.wb_valid_o   = not_empty;
  assign bus.wb_data_o    = data_mem[rd_ptr];
  assign bus.wb_flags_o   = flags_mem[rd_ptr];
  assign bus.stall_o      = stall_q;
  assign bus.count_o      = count;
  assign bus.ovf_o        = ovf_q;
  assign bus.fflags_acc_o = acc_q;
endmodule

// File: doc/fpuv_wb_buffer.md
FPUV_WB_BUFFER -- requirements
Module: fpuv_wb_buffer

Parameters
REQ-001 The block SHALL provide parameter ELEN, default 64, the result data width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 4, the number of buffer entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL provide parameter FLAGS_W, default 5, the fflags width (NV,DZ,OF,UF,NX, MSB to LSB).

Interface
REQ-004 clk_i  in  1  single clock; all state SHALL change on its rising edge only.
REQ-005 rsn_i  in  1  reset; asynchronous assert, active-low.
REQ-006 res_valid_i  in  1  FPU result valid (driven by fpuv_top result_valid_o).
REQ-007 res_data_i  in  ELEN  FPU result data (driven by result_data_o).
REQ-008 res_flags_i  in  FLAGS_W  FPU result flags (driven by result_flags_o).
REQ-009 stall_o  out  1  backpressure to the FPU (drives fpuv_top stall_i).
REQ-010 wb_valid_o  out  1  head entry available to writeback.
REQ-011 wb_ready_i  in  1  writeback consumer accepts the head entry.
REQ-012 wb_data_o  out  ELEN  head entry data.
REQ-013 wb_flags_o  out  FLAGS_W  head entry flags.
REQ-014 fflags_acc_o  out  FLAGS_W  sticky OR of the flags of all popped entries.
REQ-015 clr_fflags_i  in  1  clears fflags_acc_o.
REQ-016 flush_i  in  1  discards all buffered entries (kill).
REQ-017 count_o  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-018 ovf_o  out  1  sticky error: a result arrived while no entry was free.

Function
REQ-019 Push SHALL occur when res_valid_i=1, flush_i=0, and either count<DEPTH or a pop occurs in the same cycle.
REQ-020 Pop SHALL occur when wb_valid_o=1, wb_ready_i=1 and flush_i=0.
REQ-021 The buffer SHALL be circular with wr_ptr and rd_ptr wrapping from DEPTH-1 to 0.
REQ-022 Order SHALL be FIFO, and data and flags SHALL be stored and returned unmodified.
REQ-023 Latency SHALL be one cycle: an entry pushed at edge N appears on wb_*_o after edge N, with no combinational path from res_*_i to wb_*_o.
REQ-024 wb_valid_o SHALL be 1 exactly when count_o>0, and wb_data_o and wb_flags_o SHALL reflect the entry at rd_ptr.
REQ-025 stall_o SHALL be 1 when the registered count_o>=DEPTH-1, giving one slot of skid for a result already in flight; stall_o SHALL be driven from registers only.
REQ-026 Simultaneous push and pop SHALL leave count_o unchanged, including at count_o=DEPTH.
REQ-027 When res_valid_i=1, flush_i=0 and no push is possible, the result SHALL be dropped, ovf_o SHALL be set to 1, and the entry SHALL NOT be written.
REQ-028 On flush_i=1, pointers and count_o SHALL be cleared at the next edge, and any same-cycle push or pop SHALL be ignored.
REQ-029 fflags_acc_o and ovf_o SHALL be unaffected by flush_i.
REQ-030 On a pop, fflags_acc_o SHALL become fflags_acc_o | wb_flags_o.
REQ-031 On clr_fflags_i=1 without a pop, fflags_acc_o SHALL become 0.
REQ-032 On clr_fflags_i=1 with a same-cycle pop, fflags_acc_o SHALL become wb_flags_o (clear first, then OR).
REQ-033 ovf_o SHALL be cleared only by reset.

Reset
REQ-034 While rsn_i=0, the block SHALL asynchronously force pointers=0, count_o=0, wb_valid_o=0, stall_o=0, fflags_acc_o=0 and ovf_o=0.
REQ-035 Storage array contents SHALL NOT require reset; wb_data_o and wb_flags_o are don't-care while wb_valid_o=0.
REQ-036 Reset asserted mid-operation SHALL discard all entries with no pop observed.
REQ-037 After rsn_i deasserts, the first push SHALL be accepted at the first rising edge.

Verification
REQ-038 Push 0x3F800000 with flags 0x01 while wb_ready_i=0 -> after one edge wb_valid_o=1, wb_data_o=0x3F800000, wb_flags_o=0x01, count_o=1.
REQ-039 With DEPTH=4, push 3 results while wb_ready_i=0 -> stall_o=1 after the 3rd edge; a 4th push gives count_o=4; a 5th push gives ovf_o=1, count_o=4, and the data is lost.
REQ-040 At count_o=4, res_valid_i=1 and wb_ready_i=1 in the same cycle -> count_o stays 4, the oldest entry leaves, the new entry is last, and ovf_o stays 0.
REQ-041 Pop entries with flags 0x01, 0x04 and 0x10 -> fflags_acc_o=0x15; then clr_fflags_i=1 with a pop of flags 0x02 -> fflags_acc_o=0x02.
REQ-042 At count_o=3, flush_i=1 together with res_valid_i=1 -> count_o=0, wb_valid_o=0 and stall_o=0 next cycle, with fflags_acc_o unchanged.
REQ-043 Drive rsn_i=0 mid-stream between clock edges -> outputs are immediately at reset values, and there are no pops after release.
